// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
// Handshake and data bundle between the fetch side, the decode stage and the
// issue side.
//
// Upstream (fetch -> decode):
//   in_valid_i / in_ready_o   bundle handshake
//   in_instr_i                LANES raw 32-bit instructions, lane 0 in [31:0]
//   in_pc_i                   PC of lane 0 (lane n sits at in_pc_i + 4n)
//   in_mask_i                 per-lane valid bits
// Downstream (decode -> issue):
//   out_valid_o / out_ready_i bundle handshake
//   out_pc_o, out_mask_o      bundle PC and delivered lanes
//   out_opcode_o .. out_rs2_o decoded register/opcode fields per lane
//   out_imm_o                 sign-extended immediate per lane
//   out_illegal_o             per-lane illegal flag
//
// Handshake rule on both sides: a bundle moves on a rising clock edge where
// valid and ready are both 1. The sender holds valid and data steady until
// that edge; ready never depends combinationally on valid.
//
// Modports: slave = decode stage, master = the environment around it.
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
   parameter int XLEN  = 64,
   parameter int LANES = 2
);
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [LANES*32-1:0]     in_instr_i;
   logic [XLEN-1:0]         in_pc_i;
   logic [LANES-1:0]        in_mask_i;

   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [XLEN-1:0]         out_pc_o;
   logic [LANES-1:0]        out_mask_o;
   logic [LANES*7-1:0]      out_opcode_o;
   logic [LANES*3-1:0]      out_funct3_o;
   logic [LANES*5-1:0]      out_rd_o;
   logic [LANES*5-1:0]      out_rs1_o;
   logic [LANES*5-1:0]      out_rs2_o;
   logic [LANES*XLEN-1:0]   out_imm_o;
   logic [LANES-1:0]        out_illegal_o;

   modport slave (
      input  in_valid_i, in_instr_i, in_pc_i, in_mask_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_mask_o, out_opcode_o,
             out_funct3_o, out_rd_o, out_rs1_o, out_rs2_o, out_imm_o,
             out_illegal_o
   );

   modport master (
      output in_valid_i, in_instr_i, in_pc_i, in_mask_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_mask_o, out_opcode_o,
             out_funct3_o, out_rd_o, out_rs1_o, out_rs2_o, out_imm_o,
             out_illegal_o
   );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// Multi-lane RISC-V decode stage. Each incoming bundle is decoded
// combinationally and captured into a 2-entry FIFO, so a decoded bundle is
// visible one cycle after it is accepted.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset (wins over flush_i)
//   flush_i        drops every buffered bundle, ignores the input that cycle
//   bus            rv_decode_stage_if.slave (upstream + downstream bundles)
//   illegal_cnt_o  saturating count of delivered illegal lanes
//
// Configuration:
//   RV_DECODE_RV64I_EN  defined   -> RV64I decode, XLEN must be 64
//                       undefined -> RV32I decode, XLEN must be 32
//
// Illegal lane: the first valid lane that does not decode is delivered with
// its illegal flag set; later lanes of that bundle are dropped from the mask.
// SYSTEM accepts every funct3 except 100 (ECALL/EBREAK plus CSR accesses);
// MISC_MEM accepts only FENCE (funct3 000).
// ---------------------------------------------------------------------------
module rv_decode_stage #(
   parameter int XLEN  = 64,
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   rv_decode_stage_if.slave   bus,
   output logic [CNT_W-1:0]   illegal_cnt_o
);

`ifdef RV_DECODE_RV64I_EN
   localparam bit RV64 = 1'b1;
   if (XLEN != 64) begin : g_bad_xlen
      $error("rv_decode_stage: RV_DECODE_RV64I_EN needs XLEN=64");
   end
`else
   localparam bit RV64 = 1'b0;
   if (XLEN != 32) begin : g_bad_xlen
      $error("rv_decode_stage: RV32I build needs XLEN=32");
   end
`endif

   if (LANES < 1 || LANES > 4) begin : g_bad_lanes
      $error("rv_decode_stage: LANES must be 1..4");
   end

   // Full 7-bit opcodes; all end in 2'b11, so a compressed/garbage encoding
   // never matches any of them and falls into the illegal default.
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [LANES-1:0]       mask;
      logic [LANES*7-1:0]     opcode;
      logic [LANES*3-1:0]     funct3;
      logic [LANES*5-1:0]     rd;
      logic [LANES*5-1:0]     rs1;
      logic [LANES*5-1:0]     rs2;
      logic [LANES*XLEN-1:0]  imm;
      logic [LANES-1:0]       illegal;
   } entry_t;

   function automatic logic lane_illegal(input logic [31:0] w);
      logic [6:0] f7;
      logic [2:0] f3;
      logic       bad;
      f7  = w[31:25];
      f3  = w[14:12];
      bad = 1'b0;
      case (w[6:0])
         OPC_LUI, OPC_AUIPC, OPC_JAL: bad = 1'b0;
         OPC_JALR:     bad = (f3 != 3'b000);
         OPC_BRANCH:   bad = (f3 == 3'b010) || (f3 == 3'b011);
         OPC_LOAD:     bad = (f3 == 3'b111) ||
                             (((f3 == 3'b011) || (f3 == 3'b110)) && !RV64);
         OPC_STORE:    bad = f3[2] || ((f3 == 3'b011) && !RV64);
         OPC_OP_IMM: begin
            // RV64 shifts carry a 6-bit shamt, freeing instr[25].
            case (f3)
               3'b001:  bad = RV64 ? (w[31:26] != 6'b000000) : (f7 != 7'h00);
               3'b101:  bad = RV64 ? ((w[31:26] != 6'b000000) && (w[31:26] != 6'b010000))
                                   : ((f7 != 7'h00) && (f7 != 7'h20));
               default: bad = 1'b0;
            endcase
         end
         OPC_OP:       bad = !((f7 == 7'h00) ||
                               ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         OPC_MISC_MEM: bad = (f3 != 3'b000);
         OPC_SYSTEM:   bad = (f3 == 3'b100);
         OPC_OP_IMM_32: begin
            case (f3)
               3'b000:  bad = !RV64;
               3'b001:  bad = !RV64 || (f7 != 7'h00);
               3'b101:  bad = !RV64 || ((f7 != 7'h00) && (f7 != 7'h20));
               default: bad = 1'b1;
            endcase
         end
         OPC_OP_32: begin
            case (f3)
               3'b000, 3'b101: bad = !RV64 || ((f7 != 7'h00) && (f7 != 7'h20));
               3'b001:         bad = !RV64 || (f7 != 7'h00);
               default:        bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Immediate is assembled as 32 bits and then sign-extended to XLEN.
   function automatic logic [XLEN-1:0] lane_imm(input logic [31:0] w);
      logic [31:0] v;
      case (w[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM_32:
                      v = {{20{w[31]}}, w[31:20]};
         OPC_STORE:   v = {{20{w[31]}}, w[31:25], w[11:7]};
         OPC_BRANCH:  v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
                      v = {w[31:12], 12'b0};
         OPC_JAL:     v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default:     v = '0;
      endcase
      return XLEN'($signed(v));
   endfunction

   entry_t            dec;
   entry_t            mem0;      // head, drives the outputs
   entry_t            mem1;
   logic [1:0]        occ;
   logic [1:0]        occ_nxt;
   logic              in_ready_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              push;
   logic              pop;

   always_comb begin
      logic [31:0] w;
      logic        stop;
      dec     = '0;
      w       = '0;
      stop    = 1'b0;
      dec.pc  = bus.in_pc_i;
      for (int l = 0; l < LANES; l++) begin
         w = bus.in_instr_i[l*32 +: 32];
         dec.opcode[l*7 +: 7]    = w[6:0];
         dec.funct3[l*3 +: 3]    = w[14:12];
         dec.rd[l*5 +: 5]        = w[11:7];
         dec.rs1[l*5 +: 5]       = w[19:15];
         dec.rs2[l*5 +: 5]       = w[24:20];
         dec.imm[l*XLEN +: XLEN] = lane_imm(w);
         // Once a valid lane is illegal, nothing after it is delivered.
         if (bus.in_mask_i[l] && !stop) begin
            dec.mask[l]    = 1'b1;
            dec.illegal[l] = lane_illegal(w);
            stop           = lane_illegal(w);
         end
      end
   end

   assign push = bus.in_valid_i && in_ready_q && !flush_i;
   assign pop  = (occ != 2'd0) && bus.out_ready_i;

   always_comb begin
      occ_nxt = occ;
      if (flush_i)          occ_nxt = 2'd0;
      else if (push && !pop) occ_nxt = occ + 2'd1;
      else if (pop && !push) occ_nxt = occ - 2'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ        <= 2'd0;
         in_ready_q <= 1'b0;
         mem0       <= '0;
         mem1       <= '0;
         cnt_q      <= '0;
      end else begin
         occ        <= occ_nxt;
         // Ready is a pure register of the next occupancy, so it never
         // follows out_ready_i within a cycle.
         in_ready_q <= (occ_nxt != 2'd2);
         if (pop && (|mem0.illegal) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
         // push+pop together is only possible at occupancy 1.
         case ({push, pop})
            2'b10:   if (occ == 2'd0) mem0 <= dec; else mem1 <= dec;
            2'b01:   mem0 <= mem1;
            2'b11:   mem0 <= dec;
            default: ;
         endcase
      end
   end

   assign bus.in_ready_o    = in_ready_q;
   assign bus.out_valid_o   = (occ != 2'd0);
   assign bus.out_pc_o      = mem0.pc;
   assign bus.out_mask_o    = mem0.mask;
   assign bus.out_opcode_o  = mem0.opcode;
   assign bus.out_funct3_o  = mem0.funct3;
   assign bus.out_rd_o      = mem0.rd;
   assign bus.out_rs1_o     = mem0.rs1;
   assign bus.out_rs2_o     = mem0.rs2;
   assign bus.out_imm_o     = mem0.imm;
   assign bus.out_illegal_o = mem0.illegal;
   assign illegal_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_stage
// Directed and randomized bench for rv_decode_stage. A reference model
// (legality table + arithmetic immediate construction + bundle queue)
// predicts every output each cycle. Define RV_DECODE_RV64I_EN to build the
// RV64I variant; XLEN follows the macro. CNT_W is kept small here so the
// saturation behaviour is reached in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_rv_decode_stage;
`ifdef RV_DECODE_RV64I_EN
   localparam int XLEN = 64;
   localparam bit RV64 = 1'b1;
`else
   localparam int XLEN = 32;
   localparam bit RV64 = 1'b0;
`endif
   localparam int LANES   = 2;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [LANES-1:0]       mask;
      logic [LANES*7-1:0]     opcode;
      logic [LANES*3-1:0]     funct3;
      logic [LANES*5-1:0]     rd;
      logic [LANES*5-1:0]     rs1;
      logic [LANES*5-1:0]     rs2;
      logic [LANES*XLEN-1:0]  imm;
      logic [LANES-1:0]       illegal;
   } bundle_t;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [CNT_W-1:0] cnt;

   always #5 clk = ~clk;

   rv_decode_stage_if #(.XLEN(XLEN), .LANES(LANES)) bus ();

   rv_decode_stage #(.XLEN(XLEN), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .bus           (bus),
      .illegal_cnt_o (cnt)
   );

   // ---------------- scoreboard state ----------------
   bundle_t exp_q[$];
   int      exp_cnt = 0;
   int      n_vec   = 0;
   int      n_bad   = 0;
   bit      legal_tab[int];   // key = opcode*8 + funct3

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic build_table();
      int br[] = '{0, 1, 4, 5, 6, 7};
      int ld[] = '{0, 1, 2, 4, 5};
      for (int f = 0; f < 8; f++) begin
         legal_tab['h37*8 + f] = 1;   // LUI
         legal_tab['h17*8 + f] = 1;   // AUIPC
         legal_tab['h6f*8 + f] = 1;   // JAL
         legal_tab['h13*8 + f] = 1;   // OP_IMM
         legal_tab['h33*8 + f] = 1;   // OP
         if (f != 4) legal_tab['h73*8 + f] = 1;   // SYSTEM
      end
      legal_tab['h67*8] = 1;          // JALR
      legal_tab['h0f*8] = 1;          // FENCE
      foreach (br[i]) legal_tab['h63*8 + br[i]] = 1;
      foreach (ld[i]) legal_tab['h03*8 + ld[i]] = 1;
      for (int f = 0; f < 3; f++) legal_tab['h23*8 + f] = 1;
      if (RV64) begin
         legal_tab['h03*8 + 3] = 1;   // LD
         legal_tab['h03*8 + 6] = 1;   // LWU
         legal_tab['h23*8 + 3] = 1;   // SD
         legal_tab['h1b*8 + 0] = 1; legal_tab['h1b*8 + 1] = 1; legal_tab['h1b*8 + 5] = 1;
         legal_tab['h3b*8 + 0] = 1; legal_tab['h3b*8 + 1] = 1; legal_tab['h3b*8 + 5] = 1;
      end
   endtask

   function automatic bit ref_illegal(input logic [31:0] w);
      int op, f3, f7, imm12, shw, upper;
      op    = int'(w[6:0]);
      f3    = int'(w[14:12]);
      f7    = int'(w[31:25]);
      imm12 = int'(w[31:20]);
      if (!legal_tab.exists(op*8 + f3)) return 1'b1;
      if (op == 'h33 || op == 'h3b)
         return !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      if ((op == 'h13 || op == 'h1b) && (f3 == 1 || f3 == 5)) begin
         // Bits above the shamt field must be zero, or the SRAI marker.
         shw   = (op == 'h13 && RV64) ? 6 : 5;
         upper = imm12 >> shw;
         if (f3 == 1) return upper != 0;
         return !(upper == 0 || upper == (1024 >> shw));
      end
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w);
      longint s, v;
      s = longint'($signed(w));
      case (int'(w[6:0]))
         'h03, 'h13, 'h67, 'h1b: v = s >>> 20;
         'h23: v = (s >>> 25) * 32 + longint'(w[11:7]);
         'h63: v = (s >>> 31) * 4096 + longint'(w[7]) * 2048
                   + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         'h37, 'h17: v = (s >>> 12) * 4096;
         'h6f: v = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                   + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
         default: v = 0;
      endcase
      return XLEN'(v);
   endfunction

   function automatic bundle_t ref_bundle(input logic [LANES*32-1:0] words,
                                          input logic [XLEN-1:0] pc,
                                          input logic [LANES-1:0] m);
      bundle_t     b;
      logic [31:0] w;
      int          first;
      b     = '0;
      b.pc  = pc;
      first = LANES;
      for (int l = 0; l < LANES; l++) begin
         w = words[l*32 +: 32];
         b.opcode[l*7 +: 7]    = w[6:0];
         b.funct3[l*3 +: 3]    = w[14:12];
         b.rd[l*5 +: 5]        = w[11:7];
         b.rs1[l*5 +: 5]       = w[19:15];
         b.rs2[l*5 +: 5]       = w[24:20];
         b.imm[l*XLEN +: XLEN] = ref_imm(w);
         if (first == LANES && m[l] && ref_illegal(w)) first = l;
      end
      b.mask    = m & LANES'((2 << first) - 1);
      b.illegal = (first < LANES) ? LANES'(1 << first) : '0;
      return b;
   endfunction

   function automatic logic [31:0] rand_word();
      int          ops[] = '{'h37, 'h17, 'h6f, 'h67, 'h63, 'h03, 'h23,
                             'h13, 'h33, 'h0f, 'h73, 'h1b, 'h3b};
      logic [31:0] w;
      int          sel;
      w   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel < 13) w[6:0] = 7'(ops[sel]);
      case ($urandom_range(0, 4))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:26] = 6'b000000;
         3: w[31:26] = 6'b010000;
         default: ;
      endcase
      return w;
   endfunction

   // ---------------- driver ----------------
   // One clock: drive at negedge, check outputs against the model, then
   // advance the model at the rising edge.
   task automatic cycle(input bit v, input logic [LANES*32-1:0] ins,
                        input logic [XLEN-1:0] pc, input logic [LANES-1:0] m,
                        input bit ordy, input bit fl, output bit took);
      bit      exp_rdy, pop;
      bundle_t h;
      @(negedge clk);
      bus.in_valid_i  = v;
      bus.in_instr_i  = ins;
      bus.in_pc_i     = pc;
      bus.in_mask_i   = m;
      bus.out_ready_i = ordy;
      flush           = fl;
      exp_rdy = (exp_q.size() < 2);
      check("in_ready", 256'(bus.in_ready_o), 256'(exp_rdy));
      check("out_valid", 256'(bus.out_valid_o), 256'(exp_q.size() != 0));
      check("illegal_cnt", 256'(cnt), 256'(exp_cnt));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         check("out_pc", 256'(bus.out_pc_o), 256'(h.pc));
         check("out_mask", 256'(bus.out_mask_o), 256'(h.mask));
         check("out_illegal", 256'(bus.out_illegal_o), 256'(h.illegal));
         check("out_imm", 256'(bus.out_imm_o), 256'(h.imm));
         check("out_opcode", 256'(bus.out_opcode_o), 256'(h.opcode));
         check("out_funct3", 256'(bus.out_funct3_o), 256'(h.funct3));
         check("out_rd", 256'(bus.out_rd_o), 256'(h.rd));
         check("out_rs1", 256'(bus.out_rs1_o), 256'(h.rs1));
         check("out_rs2", 256'(bus.out_rs2_o), 256'(h.rs2));
      end
      took = v && exp_rdy && !fl;
      pop  = (exp_q.size() != 0) && ordy;
      @(posedge clk);
      if (pop) begin
         if ((|exp_q[0].illegal) && exp_cnt < CNT_MAX) exp_cnt++;
         void'(exp_q.pop_front());
      end
      if (fl) exp_q.delete();
      if (took) exp_q.push_back(ref_bundle(ins, pc, m));
   endtask

   // Reset with valid and flush also high: reset must win and drop everything.
   task automatic do_reset(input int n);
      @(negedge clk);
      rst             = 1'b1;
      flush           = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("rst_out_valid", 256'(bus.out_valid_o), 256'(0));
         check("rst_in_ready", 256'(bus.in_ready_o), 256'(0));
         check("rst_cnt", 256'(cnt), 256'(0));
      end
      rst            = 1'b0;
      flush          = 1'b0;
      bus.in_valid_i = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
   endtask

   function automatic logic [LANES*32-1:0] rand_bundle();
      logic [LANES*32-1:0] b;
      for (int l = 0; l < LANES; l++) b[l*32 +: 32] = rand_word();
      return b;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      bit                  took;
      int                  n;
      logic [LANES*32-1:0] b3;
      build_table();
      rst = 1'b1; flush = 1'b0;
      bus.in_valid_i = 1'b0; bus.in_instr_i = '0; bus.in_pc_i = '0;
      bus.in_mask_i = '0; bus.out_ready_i = 1'b0;
      do_reset(2);

      // addi x1,x0,-1 in lane 0 only
      cycle(1, {32'h0, 32'hFFF00093}, XLEN'(32'h1000), 2'b01, 0, 0, took);
      #1;
      check("addi_valid", 256'(bus.out_valid_o), 256'(1));
      check("addi_imm", 256'(bus.out_imm_o[XLEN-1:0]), 256'({XLEN{1'b1}}));
      check("addi_rd", 256'(bus.out_rd_o[4:0]), 256'(1));
      check("addi_illegal", 256'(bus.out_illegal_o), 256'(2'b00));
      check("addi_mask", 256'(bus.out_mask_o), 256'(2'b01));
      cycle(0, '0, '0, '0, 1, 0, took);

      // lane 0 all-zero (illegal) truncates lane 1
      cycle(1, {32'h00100093, 32'h0}, XLEN'(32'h2000), 2'b11, 0, 0, took);
      #1;
      check("trunc_mask", 256'(bus.out_mask_o), 256'(2'b01));
      check("trunc_illegal", 256'(bus.out_illegal_o), 256'(2'b01));
      cycle(0, '0, '0, '0, 1, 0, took);
      #1;
      check("trunc_cnt", 256'(cnt), 256'(1));

      // ld x2,0(x1): legal only on RV64
      cycle(1, {32'h0, 32'h0000B103}, XLEN'(32'h3000), 2'b01, 0, 0, took);
      #1;
      check("ld_illegal", 256'(bus.out_illegal_o[0]), 256'(!RV64));
      check("ld_funct3", 256'(bus.out_funct3_o[2:0]), 256'(3));
      check("ld_rd", 256'(bus.out_rd_o[4:0]), 256'(2));
      check("ld_rs1", 256'(bus.out_rs1_o[4:0]), 256'(1));
      cycle(0, '0, '0, '0, 1, 0, took);
      #1;
      check("ld_cnt", 256'(cnt), 256'(RV64 ? 1 : 2));

      // backpressure: two accepted, third waits for the first pop
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      #1;
      check("bp_ready_low", 256'(bus.in_ready_o), 256'(0));
      b3 = rand_bundle();
      n = 0; took = 1'b0;
      while (!took && n < 8) begin
         cycle(1, b3, XLEN'(32'h4000), 2'b11, (n >= 2), 0, took);
         n++;
      end
      check("bp_third_accept_cycle", 256'(n), 256'(4));
      repeat (3) cycle(0, '0, '0, '0, 1, 0, took);

      // flush at occupancy 2 with a bundle offered
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 1, took);
      #1;
      check("flush_valid", 256'(bus.out_valid_o), 256'(0));
      check("flush_ready", 256'(bus.in_ready_o), 256'(1));
      cycle(0, '0, '0, '0, 1, 0, took);

      // randomized traffic
      for (int i = 0; i < 800; i++)
         cycle(($urandom_range(0, 3) != 0), rand_bundle(), XLEN'({$urandom, $urandom}),
               LANES'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0), took);

      // saturate the illegal counter
      for (int i = 0; i < CNT_MAX + 40; i++)
         cycle(1, '0, XLEN'(i * 8), 2'b01, 1, 0, took);
      repeat (2) cycle(0, '0, '0, '0, 1, 0, took);
      #1;
      check("cnt_saturated", 256'(cnt), 256'(CNT_MAX));

      // reset while two bundles are buffered
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      cycle(1, rand_bundle(), XLEN'($urandom), 2'b11, 0, 0, took);
      do_reset(1);
      for (int i = 0; i < 60; i++)
         cycle(($urandom_range(0, 1) != 0), rand_bundle(), XLEN'($urandom),
               LANES'($urandom), ($urandom_range(0, 1) != 0), 0, took);
      repeat (3) cycle(0, '0, '0, '0, 1, 0, took);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, architectural register width (32 or 64).
REQ-002 SHALL have parameter LANES, default 2, instructions per bundle (1..4).
REQ-003 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 flush_i  input  1  discards all buffered bundles.
REQ-007 in_valid_i / in_ready_o  input / output  1 / 1  upstream handshake.
REQ-008 in_instr_i  input  LANES*32  raw instructions, lane 0 in bits [31:0].
REQ-009 in_pc_i  input  XLEN  PC of lane 0; lane n PC = in_pc_i + 4n.
REQ-010 in_mask_i  input  LANES  per-lane valid bits.
REQ-011 out_valid_o / out_ready_i  output / input  1 / 1  downstream handshake.
REQ-012 out_pc_o  output  XLEN  bundle PC.
REQ-013 out_mask_o  output  LANES  delivered lane valid bits.
REQ-014 out_opcode_o, out_funct3_o, out_rd_o, out_rs1_o, out_rs2_o  output  LANES*7, LANES*3, LANES*5 each  decoded fields.
REQ-015 out_imm_o  output  LANES*XLEN  sign-extended immediate per lane.
REQ-016 out_illegal_o  output  LANES  per-lane illegal flag.
REQ-017 illegal_cnt_o  output  CNT_W  count of delivered illegal lanes.

Function
REQ-018 Decode SHALL be combinational on input; result SHALL be captured into a 2-entry FIFO; latency in_valid&in_ready to out_valid = 1 cycle.
REQ-019 in_ready_o SHALL be registered: 1 when FIFO occupancy < 2 at cycle start; in_ready_o SHALL NOT depend on out_ready_i combinationally.
REQ-020 Transfers occur only when valid&ready both 1; simultaneous push and pop at occupancy 2 SHALL NOT occur (ready is 0); at occupancy 1 SHALL keep occupancy 1.
REQ-021 out_valid_o SHALL equal occupancy != 0; out_* SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Immediate SHALL be formed per format: I (LOAD, OP_IMM, JALR, OP_IMM_32), S, B (bit0=0), U (low 12 bits 0), J (bit0=0); all sign-extended from instr[31] to XLEN; R-type and SYSTEM imm SHALL be 0.
REQ-023 Lane illegal SHALL be set when: instr[1:0] != 2'b11; opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM} (plus REQ-032 set); funct3 not defined for the opcode; OP funct7 not 0x00 (or 0x20 with funct3 000/101); SRLI/SRAI/SLLI upper bits invalid.
REQ-024 In a bundle, lanes after the first illegal valid lane SHALL be cleared in out_mask_o; the illegal lane itself SHALL be delivered.
REQ-025 Masked-off input lanes SHALL output illegal=0 and not count.
REQ-026 illegal_cnt_o SHALL increase on each pop by the number of delivered illegal lanes (0 or 1 per REQ-024), saturating at 2^CNT_W-1.
REQ-027 flush_i=1 SHALL set occupancy 0 next cycle, ignore any input handshake that cycle, and leave illegal_cnt_o unchanged except for a pop completed that cycle.

Reset
REQ-028 On rst_i=1: occupancy 0, out_valid_o=0, in_ready_o=0, illegal_cnt_o=0, FIFO data 0.
REQ-029 First cycle after reset release: in_ready_o=1.
REQ-030 Reset asserted mid-transfer SHALL drop all buffered bundles; reset overrides flush_i.

Configuration
REQ-031 Macro RV_DECODE_RV64I_EN selects RV64I support.
REQ-032 Defined: OP_IMM_32, OP_32, LD (011), LWU (110), SD (011) legal; shift-immediate shamt 6 bits (instr[25] free); XLEN SHALL be 64.
REQ-033 Undefined: those opcodes/funct3 illegal; instr[25]=1 on SLLI/SRLI/SRAI illegal; XLEN SHALL be 32; elaboration error on mismatch.

Verification
REQ-034 LANES=2, lane0=0xFFF00093 (addi x1,x0,-1), mask=01 -> one cycle later out_imm lane0 = all ones, rd=1, illegal=00, mask=01.
REQ-035 RV64I_EN defined, lane0=0x0000B103 (ld x2,0(x1)) -> illegal=0, funct3=3, rd=2, rs1=1; undefined -> illegal[0]=1, illegal_cnt_o=1 after pop.
REQ-036 lane0=0x00000000, lane1=0x00100093, mask=11 -> out_mask=01, illegal=01, illegal_cnt_o=1 after pop.
REQ-037 out_ready_i=0, three back-to-back bundles -> two accepted, in_ready_o=0 from cycle 3; out_ready_i=1 -> bundles in order, third accepted after first pop.
REQ-038 occupancy 2, flush_i=1 with in_valid_i=1 -> out_valid_o=0 next cycle, input not captured, in_ready_o=1.
REQ-039 illegal_cnt_o preloaded to 0xFFFF via illegal stream -> further illegal pops keep 0xFFFF.
